gbuff_out_writer: RTL and testbench
===================================

# gbuff_out_writer

Write-side counterpart of the output global buffer check: accepts the stream of 16-bit result elements drained from the systolic array and packs four per 64-bit word. Writes them into GBUFF_OUT using the row-major layout that the top-level bench reads back against golden. In that layout, row r occupies ceil(n/4) consecutive words, and column c sits in lane c%4. The block sits inside `top` between the array drain logic and GBUFF_OUT's write port, and owns the `done` indication for a matrix job.

## Interface
- ADDR_W, 8: GBUFF_OUT address width
- LANE_W, 16: result element width
- DATA_W, 64: GBUFF_OUT word width; fixed at 4*LANE_W
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  job start pulse; sampled only in IDLE
- m  in  4  result rows (matrix A rows), latched at start
- n  in  4  result columns (matrix B cols), latched at start
- in_valid  in  1  result element valid
- in_ready  out  1  block accepts element this cycle
- in_data  in  LANE_W  result element, row-major order (r=0..m-1, c=0..n-1)
- wr_en  out  1  GBUFF_OUT write strobe
- wr_addr  out  ADDR_W  GBUFF_OUT word address
- wr_data  out  DATA_W  packed word; lane L at bits [16L+15:16L]
- done  out  1  one-cycle pulse, job complete

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0.
  - On start: latch m and n; compute words_per_row = ceil(n/4), i.e. 1 for n 1-4, 2 for n 5-8, 3 for n 9-12, 4 for n 13-15.
  - Clear the row counter r, column counter c and lane accumulator.
  - Go to RUN; if m==0 or n==0, go to DONE with no writes.
- RUN:
  - in_ready=1.
  - Beat accepted when in_valid & in_ready.
  - Accepted element goes to lane c%4 of the accumulator.
- Word completion:
  - A word completes when c%4==3 or c==n-1.
  - On completion, register a write with wr_addr = r*words_per_row + c/4.
  - wr_data = the accumulator with this beat merged; lanes not written in this word are 0.
  - Clear the accumulator on completion.
- Counter advance:
  - c increments per beat.
  - At c==n-1, c wraps to 0 and r increments.
  - Accepting the beat at r==m-1, c==n-1 goes to DONE.
- Arithmetic:
  - wr_addr is computed at ADDR_W width; max address 59 (m=15, n=15).
  - in_data is stored unmodified, with no saturation or sign handling.
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored. m and n changes after start are ignored.
- Reset (any state, including mid-row): state returns to IDLE, counters and accumulator clear, and the partial word is discarded, not written. wr_en=0, done=0, in_ready=0 from the cycle after the reset edge.

## Timing
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, done=0.
- in_ready is a registered state decode. It is 1 from the first cycle after the start edge and returns to 0 in the cycle following acceptance of the final beat.
- Write latency: a completing beat accepted at edge k gives wr_en=1 with a valid wr_addr/wr_data for exactly the cycle between edges k and k+1. wr_en is high for a single cycle per word.
- Throughput: one element per cycle, no stalls. A write and the next beat's acceptance overlap freely.
- done is asserted in the same cycle as the final wr_en, i.e. the cycle after the last beat is accepted.
- Empty job (m==0 or n==0): done is asserted in the cycle after the start edge; wr_en is never asserted.
- Gaps in in_valid only pause the counters; the accumulator holds its contents across gaps.
- start asserted in the same cycle as done is ignored; the block must be in IDLE first.
- Total cycles with no valid gaps: m*n acceptances, then done in the next cycle.

## Test plan
- m=4, n=4, elements 0x0001..0x0010 streamed back-to-back:
  - 4 writes at addr 0..3.
  - addr0 = 0x0004_0003_0002_0001, addr3 = 0x0010_000F_000E_000D.
  - done pulses in the cycle after the 16th acceptance.
- m=1, n=6, elements 0x0001..0x0006 with in_valid deasserted for 3 cycles after the 2nd beat:
  - addr0 = 0x0004_0003_0002_0001.
  - addr1 = 0x0000_0000_0006_0005.
  - Exactly 2 writes.
- m=2, n=9, element value = 0x0100*r + c:
  - words_per_row=3, 6 writes.
  - addr3 = 0x0103_0102_0101_0100.
  - addr5 = 0x0000_0000_0000_0108.
- m=15, n=15: 60 writes, last at addr 59 with lanes 0-2 populated and lane 3 = 0. A start pulse issued mid-job is ignored.
- Reset mid-job: m=3, n=4, rst asserted after the 6th beat.
  - Only addr0 is written; the lanes for row 1 are never written.
  - All outputs are 0 in the next cycle.
  - A new job with m=1, n=4 then writes addr0 correctly.
- m=0, n=5: no wr_en; done=1 in the cycle after the start edge; in_ready stays 0.

Source files
------------

// File: rtl/gbuff_out_writer.sv
// gbuff_out_writer
//   Packs the row-major stream of 16-bit result elements drained from the
//   systolic array into 64-bit GBUFF_OUT words (four lanes per word). Row r
//   takes ceil(n/4) consecutive words, and column c lands in lane c%4 of word
//   r*words_per_row + c/4. The block also raises the job-complete pulse.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, m, n       job start pulse (taken only in IDLE) with matrix dims
//   in_valid/in_ready element handshake; in_data is the element
//   wr_en/wr_addr/wr_data  GBUFF_OUT write port (one cycle per word)
//   done              one-cycle job-complete pulse
module gbuff_out_writer #(
    parameter int ADDR_W = 8,
    parameter int LANE_W = 16,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        m,
    input  logic [3:0]        n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANE_W-1:0] in_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        m_q, m_d;
    logic [3:0]        n_q, n_d;
    logic [2:0]        wpr_q, wpr_d;
    logic [3:0]        r_q, r_d;
    logic [3:0]        c_q, c_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] merged;
    logic              last_col;

    // Word address of element (r, c); the product never exceeds 14*4.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [3:0] r,
                                                    input logic [2:0] wpr,
                                                    input logic [3:0] c);
        logic [ADDR_W-1:0] base;
        base = ADDR_W'(r) * ADDR_W'(wpr);
        return base + ADDR_W'(c[3:2]);
    endfunction

    // ceil(n/4) for n in 0..15.
    function automatic logic [2:0] words_per_row(input logic [3:0] cols);
        logic [4:0] sum;
        sum = {1'b0, cols} + 5'd3;
        return sum[4:2];
    endfunction

    always_comb begin
        merged = acc_q;
        merged[c_q[1:0]*LANE_W +: LANE_W] = in_data;
        last_col = (c_q == n_q - 4'd1);
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        n_d       = n_q;
        wpr_d     = wpr_q;
        r_d       = r_q;
        c_d       = c_q;
        acc_d     = acc_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = m;
                    n_d     = n;
                    wpr_d   = words_per_row(n);
                    r_d     = '0;
                    c_d     = '0;
                    acc_d   = '0;
                    state_d = (m == 4'd0 || n == 4'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (in_valid && in_ready_q) begin
                    // A word closes on lane 3 or on the short tail of a row;
                    // lanes never written in that word stay zero.
                    if (c_q[1:0] == 2'd3 || last_col) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = word_addr(r_q, wpr_q, c_q);
                        wr_data_d = merged;
                        acc_d     = '0;
                    end else begin
                        acc_d = merged;
                    end
                    if (last_col) begin
                        c_d = '0;
                        r_d = r_q + 4'd1;
                        if (r_q == m_q - 4'd1) begin
                            state_d = DONE;
                        end
                    end else begin
                        c_d = c_q + 4'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == RUN);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            m_q        <= '0;
            n_q        <= '0;
            wpr_q      <= '0;
            r_q        <= '0;
            c_q        <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            n_q        <= n_d;
            wpr_q      <= wpr_d;
            r_q        <= r_d;
            c_q        <= c_d;
            acc_q      <= acc_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign done     = done_q;

endmodule

// File: tb/tb_gbuff_out_writer.sv
module tb_gbuff_out_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  m;
    logic [3:0]  n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [63:0] wr_data;
    logic        done;

    gbuff_out_writer #(.ADDR_W(8), .LANE_W(16), .DATA_W(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .m        (m),
        .n        (n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .done     (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Edge counter: between edge k and k+1 it reads k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write/handshake monitor, sampled on the falling edge.
    logic [63:0] mem [0:255];
    bit          wrote [0:255];
    int          nwr, ndone, nacc;
    int          last_acc, done_cyc, last_wr_cyc, last_addr;
    bit          ready_seen;

    always @(negedge clk) begin
        if (wr_en) begin
            mem[wr_addr]   = wr_data;
            wrote[wr_addr] = 1'b1;
            nwr++;
            last_wr_cyc = cyc;
            last_addr   = int'(wr_addr);
        end
        if (done) begin
            ndone++;
            done_cyc = cyc;
        end
        if (in_ready) ready_seen = 1'b1;
        if (in_valid && in_ready) begin
            nacc++;
            last_acc = cyc + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 256; i++) begin
            mem[i]   = '0;
            wrote[i] = 1'b0;
        end
        nwr = 0; ndone = 0; nacc = 0;
        last_acc = -1; done_cyc = -1; last_wr_cyc = -2; last_addr = -1;
        ready_seen = 1'b0;
    endtask

    task automatic cycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int mm, input int nn, output int start_edge);
        clear_mon();
        start = 1'b1;
        m = 4'(mm);
        n = 4'(nn);
        cycles(1);
        start = 1'b0;
        start_edge = cyc;
    endtask

    // Presents one element and holds it until accepted (bounded wait).
    task automatic send_beat(input logic [15:0] v, input bit pulse_start);
        int guard;
        in_valid = 1'b1;
        in_data  = v;
        guard = 0;
        while (!in_ready && guard < 20) begin
            cycles(1);
            guard++;
        end
        if (guard >= 20) check("beat_accept_timeout", 64'(guard), 64'd0);
        if (pulse_start) begin
            start = 1'b1;
            m = 4'd1;
            n = 4'd1;
        end
        cycles(1);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    function automatic logic [15:0] elem(input int mode, input int idx, input int nn);
        case (mode)
            0:       return 16'(idx + 1);
            1:       return 16'(((idx / nn) << 8) + (idx % nn));
            default: return 16'(16'h00A0 + idx);
        endcase
    endfunction

    task automatic stream(input int mm, input int nn, input int mode,
                          input int gap_after, input int gap_len, input int start_at);
        for (int i = 0; i < mm * nn; i++) begin
            send_beat(elem(mode, i, nn), i == start_at);
            if (i + 1 == gap_after) cycles(gap_len);
        end
        cycles(4);
    endtask

    int se;

    initial begin
        rst = 1'b1; start = 1'b0; m = '0; n = '0; in_valid = 1'b0; in_data = '0;
        clear_mon();
        cycles(3);
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_wr_en",    64'(wr_en),    64'd0);
        check("rst_wr_addr",  64'(wr_addr),  64'd0);
        check("rst_wr_data",  wr_data,       64'd0);
        check("rst_done",     64'(done),     64'd0);
        cycles(2);

        // 4x4, back-to-back
        start_job(4, 4, se);
        check("t1_ready_after_start", 64'(in_ready), 64'd1);
        stream(4, 4, 0, -1, 0, -1);
        check("t1_nwr",   64'(nwr), 64'd4);
        check("t1_addr0", mem[0], 64'h0004_0003_0002_0001);
        check("t1_addr1", mem[1], 64'h0008_0007_0006_0005);
        check("t1_addr3", mem[3], 64'h0010_000F_000E_000D);
        check("t1_ndone", 64'(ndone), 64'd1);
        check("t1_done_timing", 64'(done_cyc), 64'(last_acc));
        check("t1_done_with_last_wr", 64'(done_cyc), 64'(last_wr_cyc));
        check("t1_ready_low_after", 64'(in_ready), 64'd0);

        // 1x6 with a 3-cycle gap after the 2nd beat
        start_job(1, 6, se);
        stream(1, 6, 0, 2, 3, -1);
        check("t2_nwr",   64'(nwr), 64'd2);
        check("t2_addr0", mem[0], 64'h0004_0003_0002_0001);
        check("t2_addr1", mem[1], 64'h0000_0000_0006_0005);
        check("t2_ndone", 64'(ndone), 64'd1);

        // 2x9, value = 0x100*r + c
        start_job(2, 9, se);
        stream(2, 9, 1, -1, 0, -1);
        check("t3_nwr",   64'(nwr), 64'd6);
        check("t3_addr2", mem[2], 64'h0000_0000_0000_0008);
        check("t3_addr3", mem[3], 64'h0103_0102_0101_0100);
        check("t3_addr5", mem[5], 64'h0000_0000_0000_0108);

        // 15x15 with a stray start (and new m/n) mid-job
        start_job(15, 15, se);
        stream(15, 15, 1, -1, 0, 40);
        check("t4_nwr",       64'(nwr), 64'd60);
        check("t4_last_addr", 64'(last_addr), 64'd59);
        check("t4_addr59",    mem[59], 64'h0000_0E0E_0E0D_0E0C);
        check("t4_addr0",     mem[0],  64'h0003_0002_0001_0000);
        check("t4_nacc",      64'(nacc), 64'd225);
        check("t4_ndone",     64'(ndone), 64'd1);

        // Reset after the 6th beat of a 3x4 job
        start_job(3, 4, se);
        for (int i = 0; i < 6; i++) send_beat(elem(0, i, 4), 1'b0);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("t5_rst_in_ready", 64'(in_ready), 64'd0);
        check("t5_rst_wr_en",    64'(wr_en),    64'd0);
        check("t5_rst_wr_addr",  64'(wr_addr),  64'd0);
        check("t5_rst_wr_data",  wr_data,       64'd0);
        check("t5_rst_done",     64'(done),     64'd0);
        cycles(3);
        check("t5_nwr",    64'(nwr), 64'd1);
        check("t5_addr0",  mem[0], 64'h0004_0003_0002_0001);
        check("t5_row1_unwritten", 64'(wrote[1]), 64'd0);
        check("t5_ndone",  64'(ndone), 64'd0);
        start_job(1, 4, se);
        stream(1, 4, 2, -1, 0, -1);
        check("t5b_nwr",   64'(nwr), 64'd1);
        check("t5b_addr0", mem[0], 64'h00A3_00A2_00A1_00A0);

        // Empty job
        start_job(0, 5, se);
        cycles(4);
        check("t6_nwr",        64'(nwr), 64'd0);
        check("t6_ndone",      64'(ndone), 64'd1);
        check("t6_done_timing", 64'(done_cyc), 64'(se));
        check("t6_ready_never", 64'(ready_seen), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
